// File: rtl/fetch_stage.sv
// Stage-0 instruction fetch for the rv64 in-order core: PC owner, single-outstanding imem requests.
// Define FETCH_BYPASS_EN to forward a response straight to decode in WAIT, skipping HOLD.
module fetch_stage #(
  parameter int unsigned      WIDTH      = 64,
  parameter int unsigned      INSTR_SIZE = 32,
  parameter logic [WIDTH-1:0] RESET_PC   = 64'h0000_0000_8000_0000
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  redirect_valid,
  input  logic [WIDTH-1:0]      redirect_pc,
  output logic                  imem_req_valid,
  output logic [WIDTH-1:0]      imem_req_addr,
  input  logic                  imem_req_ready,
  input  logic                  imem_resp_valid,
  input  logic [INSTR_SIZE-1:0] imem_resp_data,
  output logic                  fetch_to_regD_valid,
  input  logic                  regD_allow_in,
  output logic [WIDTH-1:0]      fetch_pc,
  output logic [INSTR_SIZE-1:0] fetch_instr
);

  localparam logic [1:0] StReq  = 2'd0;
  localparam logic [1:0] StWait = 2'd1;
  localparam logic [1:0] StHold = 2'd2;
  localparam logic [1:0] StDrop = 2'd3;

  logic [1:0]            state_q, state_d;
  logic [WIDTH-1:0]      pc_q, pc_d;
  logic [WIDTH-1:0]      fetch_pc_q, fetch_pc_d;
  logic [INSTR_SIZE-1:0] fetch_instr_q, fetch_instr_d;
  logic [WIDTH-1:0]      pc_inc;
  logic                  bypass;

  assign pc_inc = pc_q + WIDTH'(4);

`ifdef FETCH_BYPASS_EN
  assign bypass = (state_q == StWait) && imem_resp_valid && regD_allow_in && !redirect_valid;
`else
  assign bypass = 1'b0;
`endif

  // A redirect suppresses both the request and the decode handshake in its own cycle.
  assign imem_req_valid      = (state_q == StReq) && !redirect_valid;
  assign imem_req_addr       = pc_q;
  assign fetch_to_regD_valid = ((state_q == StHold) && !redirect_valid) || bypass;
  assign fetch_pc            = bypass ? pc_q : fetch_pc_q;
  assign fetch_instr         = bypass ? imem_resp_data : fetch_instr_q;

  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    fetch_pc_d    = fetch_pc_q;
    fetch_instr_d = fetch_instr_q;
    case (state_q)
      StReq: begin
        if (redirect_valid) begin
          pc_d = redirect_pc;
        end else if (imem_req_ready) begin
          state_d = StWait;
        end
      end
      StWait: begin
        if (redirect_valid) begin
          pc_d    = redirect_pc;
          state_d = imem_resp_valid ? StReq : StDrop;
        end else if (imem_resp_valid) begin
          fetch_pc_d    = pc_q;
          fetch_instr_d = imem_resp_data;
          if (bypass) begin
            pc_d    = pc_inc;
            state_d = StReq;
          end else begin
            state_d = StHold;
          end
        end
      end
      StHold: begin
        if (redirect_valid) begin
          pc_d    = redirect_pc;
          state_d = StReq;
        end else if (regD_allow_in) begin
          pc_d    = pc_inc;
          state_d = StReq;
        end
      end
      StDrop: begin
        // Wrong-path response still owed by memory; swallow it before issuing again.
        if (redirect_valid) begin
          pc_d = redirect_pc;
        end
        if (imem_resp_valid) begin
          state_d = StReq;
        end
      end
      default: state_d = StReq;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= StReq;
      pc_q          <= RESET_PC;
      fetch_pc_q    <= '0;
      fetch_instr_q <= '0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      fetch_pc_q    <= fetch_pc_d;
      fetch_instr_q <= fetch_instr_d;
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
// Scoreboard bench for fetch_stage: a latency-programmable memory model feeds responses,
// expected {pc, instr} pairs are queued on response and popped on each decode transfer.
module tb_fetch_stage;

  localparam logic [63:0] RstPc = 64'h0000_0000_8000_0000;
`ifdef FETCH_BYPASS_EN
  localparam int ExpGap = 2;
  localparam logic Byp = 1'b1;
`else
  localparam int ExpGap = 3;
  localparam logic Byp = 1'b0;
`endif

  logic        clk;
  logic        rst;
  logic        redirect_valid;
  logic [63:0] redirect_pc;
  logic        imem_req_valid;
  logic [63:0] imem_req_addr;
  logic        imem_req_ready;
  logic        imem_resp_valid;
  logic [31:0] imem_resp_data;
  logic        fetch_to_regD_valid;
  logic        regD_allow_in;
  logic [63:0] fetch_pc;
  logic [31:0] fetch_instr;

  fetch_stage dut (
    .clk                 (clk),
    .rst                 (rst),
    .redirect_valid      (redirect_valid),
    .redirect_pc         (redirect_pc),
    .imem_req_valid      (imem_req_valid),
    .imem_req_addr       (imem_req_addr),
    .imem_req_ready      (imem_req_ready),
    .imem_resp_valid     (imem_resp_valid),
    .imem_resp_data      (imem_resp_data),
    .fetch_to_regD_valid (fetch_to_regD_valid),
    .regD_allow_in       (regD_allow_in),
    .fetch_pc            (fetch_pc),
    .fetch_instr         (fetch_instr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [63:0] pc;
    logic [31:0] instr;
  } xfer_t;

  xfer_t       sb_q[$];
  int          n_cmp, n_fail;
  int          cyc, xfer_cnt, last_xfer_cyc, gap;
  logic [63:0] exp_pc, out_pc;
  logic        outstanding, killed;
  logic        obs_valid, obs_req_valid, obs_resp, obs_xfer, obs_fire;
  logic [63:0] obs_pc, obs_req_addr;
  logic [31:0] obs_instr;
  int          resp_lat, mem_cnt;
  logic        mem_busy;
  logic [63:0] mem_addr;

  function automatic logic [31:0] instr_of(input logic [63:0] a);
    return 32'h0000_0013 ^ {a[29:0], 2'b00};
  endfunction

  // One clock: observe and score at negedge, then drive the memory model just after posedge.
  task automatic tick();
    xfer_t       e;
    logic        fire_s;
    logic [63:0] raddr;
    @(negedge clk);
    cyc++;
    obs_valid     = fetch_to_regD_valid;
    obs_pc        = fetch_pc;
    obs_instr     = fetch_instr;
    obs_req_valid = imem_req_valid;
    obs_req_addr  = imem_req_addr;
    obs_resp      = imem_resp_valid;
    obs_xfer      = 1'b0;
    fire_s        = !rst && imem_req_valid && imem_req_ready;
    obs_fire      = fire_s;
    raddr         = imem_req_addr;
    if (rst) begin
      exp_pc      = RstPc;
      sb_q.delete();
      outstanding = 1'b0;
      killed      = 1'b0;
    end else begin
      if (redirect_valid) begin
        exp_pc = redirect_pc;
        if (outstanding && !imem_resp_valid) killed = 1'b1;
        sb_q.delete();
      end
      if (imem_resp_valid) begin
        if (outstanding && !killed && !redirect_valid)
          sb_q.push_back('{pc: out_pc, instr: instr_of(out_pc)});
        outstanding = 1'b0;
        killed      = 1'b0;
      end
      if (fetch_to_regD_valid && regD_allow_in) begin
        obs_xfer      = 1'b1;
        xfer_cnt++;
        gap           = cyc - last_xfer_cyc;
        last_xfer_cyc = cyc;
        n_cmp++;
        if (sb_q.size() == 0) begin
          n_fail++;
          $display("FAIL xfer_unexpected: got pc %h instr %h, want no transfer", fetch_pc,
                   fetch_instr);
        end else begin
          e = sb_q.pop_front();
          if (fetch_pc !== e.pc || fetch_instr !== e.instr) begin
            n_fail++;
            $display("FAIL xfer_data: got pc %h instr %h, want pc %h instr %h", fetch_pc,
                     fetch_instr, e.pc, e.instr);
          end
          exp_pc = e.pc + 64'd4;
        end
      end
      if (fire_s) begin
        n_cmp++;
        if (raddr !== exp_pc) begin
          n_fail++;
          $display("FAIL req_addr: got %h, want %h", raddr, exp_pc);
        end
        outstanding = 1'b1;
        out_pc      = exp_pc;
      end
    end
    @(posedge clk);
    #1;
    imem_resp_valid = 1'b0;
    imem_resp_data  = 32'hDEAD_BEEF;
    if (fire_s) begin
      mem_busy = 1'b1;
      mem_addr = raddr;
      mem_cnt  = resp_lat;
    end
    if (mem_busy) begin
      mem_cnt--;
      if (mem_cnt == 0) begin
        imem_resp_valid = 1'b1;
        imem_resp_data  = instr_of(mem_addr);
        mem_busy        = 1'b0;
      end
    end
  endtask

  task automatic tick_until_fire(output logic ok);
    ok = 1'b0;
    for (int k = 0; k < 20; k++) begin
      tick();
      if (obs_fire) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic tick_until_valid(output logic ok);
    ok = 1'b0;
    for (int k = 0; k < 20; k++) begin
      tick();
      if (obs_valid) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; redirect_valid = 1'b0; redirect_pc = '0; imem_req_ready = 1'b0;
    imem_resp_valid = 1'b0; imem_resp_data = '0; regD_allow_in = 1'b0; resp_lat = 1;
    repeat (3) tick();
    rst = 1'b0;
    tick();
    n_cmp++; if (obs_req_valid !== 1'b1) begin n_fail++;
      $display("FAIL reset_req_valid: got %b, want 1", obs_req_valid); end
    n_cmp++; if (obs_req_addr !== RstPc) begin n_fail++;
      $display("FAIL reset_req_addr: got %h, want %h", obs_req_addr, RstPc); end
    n_cmp++; if (obs_valid !== 1'b0) begin n_fail++;
      $display("FAIL reset_valid: got %b, want 0", obs_valid); end
    n_cmp++; if (obs_pc !== 64'd0 || obs_instr !== 32'd0) begin n_fail++;
      $display("FAIL reset_fetch_regs: got pc %h instr %h, want 0/0", obs_pc, obs_instr); end
  endtask

  task automatic test_basic();
    logic ok;
    imem_req_ready = 1'b1; regD_allow_in = 1'b1; resp_lat = 1;
    tick_until_fire(ok);
    n_cmp++; if (ok !== 1'b1 || obs_req_addr !== RstPc) begin n_fail++;
      $display("FAIL basic_first_req: got ok %b addr %h, want 1 %h", ok, obs_req_addr, RstPc); end
    tick_until_valid(ok);
    n_cmp++; if (ok !== 1'b1 || obs_pc !== RstPc || obs_instr !== 32'h0000_0013) begin n_fail++;
      $display("FAIL basic_first_instr: got ok %b pc %h instr %h, want 1 %h 00000013", ok,
               obs_pc, obs_instr, RstPc); end
    tick_until_fire(ok);
    n_cmp++; if (ok !== 1'b1 || obs_req_addr !== 64'h8000_0004) begin n_fail++;
      $display("FAIL basic_next_req: got ok %b addr %h, want 1 80000004", ok, obs_req_addr); end
  endtask

  task automatic test_backpressure();
    logic        ok;
    logic [63:0] p0;
    logic [31:0] i0;
    int          x0;
    regD_allow_in = 1'b0;
    tick_until_valid(ok);
    p0 = obs_pc; i0 = obs_instr;
    n_cmp++; if (ok !== 1'b1) begin n_fail++; $display("FAIL bp_reach_hold: got 0, want 1"); end
    for (int k = 0; k < 5; k++) begin
      tick();
      n_cmp++; if (obs_valid !== 1'b1 || obs_pc !== p0 || obs_instr !== i0) begin n_fail++;
        $display("FAIL bp_hold_stable: got v %b pc %h instr %h, want 1 %h %h", obs_valid,
                 obs_pc, obs_instr, p0, i0); end
      n_cmp++; if (obs_req_valid !== 1'b0) begin n_fail++;
        $display("FAIL bp_no_req: got %b, want 0", obs_req_valid); end
    end
    regD_allow_in = 1'b1;
    x0 = xfer_cnt;
    tick();
    n_cmp++; if (xfer_cnt !== x0 + 1) begin n_fail++;
      $display("FAIL bp_single_xfer: got %0d, want %0d", xfer_cnt, x0 + 1); end
    tick();
    n_cmp++; if (obs_req_valid !== 1'b1 || obs_req_addr !== p0 + 64'd4 || obs_valid !== 1'b0)
    begin n_fail++;
      $display("FAIL bp_next_req: got v %b addr %h fv %b, want 1 %h 0", obs_req_valid,
               obs_req_addr, obs_valid, p0 + 64'd4); end
  endtask

  task automatic test_redirect_wait();
    logic ok;
    logic resp_seen;
    int   x0;
    regD_allow_in = 1'b1; resp_lat = 3;
    tick_until_fire(ok);
    redirect_valid = 1'b1; redirect_pc = 64'h8000_1000;
    x0 = xfer_cnt;
    tick();
    redirect_valid = 1'b0;
    ok = 1'b0; resp_seen = 1'b0;
    for (int k = 0; k < 10; k++) begin
      tick();
      if (obs_resp) resp_seen = 1'b1;
      if (obs_fire) begin ok = 1'b1; break; end
    end
    n_cmp++; if (ok !== 1'b1 || resp_seen !== 1'b1 || obs_req_addr !== 64'h8000_1000) begin
      n_fail++;
      $display("FAIL rw_next_req: got ok %b resp %b addr %h, want 1 1 80001000", ok, resp_seen,
               obs_req_addr); end
    n_cmp++; if (xfer_cnt !== x0) begin n_fail++;
      $display("FAIL rw_dropped: got %0d transfers, want 0", xfer_cnt - x0); end
  endtask

  task automatic test_redirect_hold();
    logic ok;
    int   x0;
    resp_lat = 1; regD_allow_in = 1'b0;
    tick_until_valid(ok);
    regD_allow_in = 1'b1; redirect_valid = 1'b1; redirect_pc = 64'h8000_2000;
    x0 = xfer_cnt;
    tick();
    redirect_valid = 1'b0;
    n_cmp++; if (ok !== 1'b1 || obs_valid !== 1'b0 || xfer_cnt !== x0) begin n_fail++;
      $display("FAIL rh_no_xfer: got ok %b valid %b xfers %0d, want 1 0 0", ok, obs_valid,
               xfer_cnt - x0); end
    tick_until_fire(ok);
    n_cmp++; if (ok !== 1'b1 || obs_req_addr !== 64'h8000_2000) begin n_fail++;
      $display("FAIL rh_next_req: got ok %b addr %h, want 1 80002000", ok, obs_req_addr); end
  endtask

  task automatic test_wrap();
    logic ok;
    imem_req_ready = 1'b0; regD_allow_in = 1'b1;
    repeat (4) tick();
    redirect_valid = 1'b1; redirect_pc = 64'hFFFF_FFFF_FFFF_FFFC;
    tick();
    redirect_valid = 1'b0; imem_req_ready = 1'b1;
    tick_until_fire(ok);
    n_cmp++; if (ok !== 1'b1 || obs_req_addr !== 64'hFFFF_FFFF_FFFF_FFFC) begin n_fail++;
      $display("FAIL wrap_req: got ok %b addr %h, want 1 fffffffffffffffc", ok, obs_req_addr); end
    tick_until_valid(ok);
    n_cmp++; if (ok !== 1'b1 || obs_pc !== 64'hFFFF_FFFF_FFFF_FFFC) begin n_fail++;
      $display("FAIL wrap_xfer: got ok %b pc %h, want 1 fffffffffffffffc", ok, obs_pc); end
    tick_until_fire(ok);
    n_cmp++; if (ok !== 1'b1 || obs_req_addr !== 64'd0) begin n_fail++;
      $display("FAIL wrap_zero: got ok %b addr %h, want 1 0", ok, obs_req_addr); end
  endtask

  task automatic test_back_to_back();
    int nx;
    imem_req_ready = 1'b1; regD_allow_in = 1'b1; resp_lat = 1;
    nx = 0;
    for (int k = 0; k < 30; k++) begin
      tick();
      if (obs_xfer) begin
        if (nx > 0) begin
          n_cmp++; if (gap !== ExpGap) begin n_fail++;
            $display("FAIL b2b_gap: got %0d cycles, want %0d", gap, ExpGap); end
        end
        n_cmp++; if (obs_resp !== Byp) begin n_fail++;
          $display("FAIL b2b_resp_same_cycle: got %b, want %b", obs_resp, Byp); end
        nx++;
      end
    end
    n_cmp++; if (nx < 30 / ExpGap - 2) begin n_fail++;
      $display("FAIL b2b_count: got %0d, want at least %0d", nx, 30 / ExpGap - 2); end
  endtask

  task automatic test_reset_mid();
    logic ok;
    resp_lat = 3; imem_req_ready = 1'b1; regD_allow_in = 1'b1;
    tick_until_fire(ok);
    imem_req_ready = 1'b0; rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int k = 0; k < 4; k++) begin
      tick();
      n_cmp++; if (obs_valid !== 1'b0 || obs_req_addr !== RstPc || obs_pc !== 64'd0) begin
        n_fail++;
        $display("FAIL midrst_state: got v %b addr %h pc %h, want 0 %h 0", obs_valid,
                 obs_req_addr, obs_pc, RstPc); end
    end
    imem_req_ready = 1'b1; resp_lat = 1;
    tick_until_valid(ok);
    n_cmp++; if (ok !== 1'b1 || obs_pc !== RstPc || obs_instr !== 32'h0000_0013) begin n_fail++;
      $display("FAIL midrst_refetch: got ok %b pc %h instr %h, want 1 %h 00000013", ok, obs_pc,
               obs_instr, RstPc); end
    repeat (4) tick();
  endtask

  initial begin
    n_cmp = 0; n_fail = 0; cyc = 0; xfer_cnt = 0; last_xfer_cyc = 0; gap = 0;
    exp_pc = RstPc; out_pc = '0; outstanding = 1'b0; killed = 1'b0;
    mem_busy = 1'b0; mem_cnt = 0; mem_addr = '0;
    test_reset();
    test_basic();
    test_backpressure();
    test_redirect_wait();
    test_redirect_hold();
    test_wrap();
    test_back_to_back();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got simulation still running, want finished");
    $fatal(1, "watchdog expired");
  end

endmodule
